// File: rtl/pattern_detector_param.sv
// Streaming pattern detector: matches a run-time programmed sequence of 1..MAX_LEN symbols
// on a valid-qualified stream, with found/ack handshake, sticky overrun and a saturating match counter.

// One comparator per pattern position: selects the window symbol that must line up with
// pattern symbol j for the currently configured length.
module pd_sym_cmp #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int IW      = 3
) (
  input  logic [MAX_LEN-1:0][DATA_W-1:0] win_i,
  input  logic [IW-1:0]                  sel_i,
  input  logic [DATA_W-1:0]              ref_i,
  input  logic                           act_i,
  output logic                           hit_o
);
  assign hit_o = !act_i || (win_i[sel_i] == ref_i);
endmodule

module pattern_detector_param #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter bit OVERLAP = 1'b1,
  localparam int LW     = $clog2(MAX_LEN+1),
  localparam int IW     = $clog2(MAX_LEN)
) (
  input  logic                      clk,
  input  logic                      reset_sync,
  input  logic                      enable,
  input  logic                      cfg_load,
  input  logic [MAX_LEN*DATA_W-1:0] pattern,
  input  logic [LW-1:0]             pattern_len,
  input  logic [DATA_W-1:0]         data,
  input  logic                      data_valid,
  input  logic                      ack,
  output logic                      found_pattern,
  output logic                      overrun,
  output logic [CNT_W-1:0]          match_count
);

  typedef enum logic [1:0] {IDLE, SEARCH, PENDING} state_e;

  state_e                          state_q, state_d;
  logic [MAX_LEN-1:0][DATA_W-1:0]  hist_q, hist_d;
  logic [MAX_LEN-1:0][DATA_W-1:0]  pat_q;
  logic [LW-1:0]                   len_q, fill_q, fill_d, fill_nxt, len_ld;
  logic                            found_q, found_d, ovr_q, ovr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            accept, match, ld;
  logic [MAX_LEN-1:0][DATA_W-1:0]  win;
  logic [MAX_LEN-1:0]              hits;

  assign accept   = enable && data_valid;
  assign ld       = cfg_load && !enable;
  assign len_ld   = (pattern_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : pattern_len;
  assign fill_nxt = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);

  // win[0] is the symbol being accepted now, win[k] the k-th previously accepted one
  assign win = {hist_q[MAX_LEN-2:0], data};

  for (genvar j = 0; j < MAX_LEN; j++) begin : g_cmp
    logic [LW-1:0] sel_full;
    assign sel_full = len_q - LW'(j + 1);
    pd_sym_cmp #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .IW(IW)) u_cmp (
      .win_i (win),
      .sel_i (IW'(sel_full)),
      .ref_i (pat_q[j]),
      .act_i (LW'(j) < len_q),
      .hit_o (hits[j])
    );
  end

  assign match = accept && (len_q != '0) && (fill_nxt >= len_q) && (&hits);

  always_comb begin
    state_d = state_q;
    found_d = found_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    hist_d  = hist_q;
    fill_d  = fill_q;

    if (match)    found_d = 1'b1;
    else if (ack) found_d = 1'b0;

    if (match && found_q && !ack) ovr_d = 1'b1;
    if (match && (cnt_q != '1))   cnt_d = cnt_q + CNT_W'(1);
    if (ld) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end

    if (!enable) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = {hist_q[MAX_LEN-2:0], data};
      fill_d = (match && !OVERLAP) ? '0 : fill_nxt;
    end

    unique case (state_q)
      IDLE:    state_d = SEARCH;
      SEARCH:  if (match) state_d = PENDING;
      PENDING: if (ack && !match) state_d = SEARCH;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      found_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      found_q <= found_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      if (ld) begin
        pat_q <= pattern;
        len_q <= len_ld;
      end
    end
  end

  assign found_pattern = found_q;
  assign overrun       = ovr_q;
  assign match_count   = cnt_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench: two detectors (overlap / non-overlap) driven in parallel and compared every cycle
// against a queue-based reference of the detection rules.
module tb_pattern_detector_param;
  localparam int DW = 8;
  localparam int ML = 8;
  localparam int CW = 16;
  localparam int LW = $clog2(ML+1);

  typedef logic [DW-1:0] sym_q_t[$];

  logic              clk = 1'b0;
  logic              reset_sync;
  logic              enable, cfg_load, data_valid, ack;
  logic [ML*DW-1:0]  pattern;
  logic [LW-1:0]     pattern_len;
  logic [DW-1:0]     data;
  logic              fnd [2];
  logic              ovr [2];
  logic [CW-1:0]     cnt [2];

  int n_chk = 0;
  int n_err = 0;

  // reference state; index 1 = overlapping, 0 = non-overlapping
  sym_q_t        hq0, hq1;
  logic [DW-1:0] m_pat [ML];
  int            m_len;
  bit            m_fnd [2];
  bit            m_ovr [2];
  int            m_cnt [2];

  always #5 clk = ~clk;

  pattern_detector_param #(.DATA_W(DW), .MAX_LEN(ML), .CNT_W(CW), .OVERLAP(1'b1)) u_ov (
    .clk(clk), .reset_sync(reset_sync), .enable(enable), .cfg_load(cfg_load),
    .pattern(pattern), .pattern_len(pattern_len), .data(data), .data_valid(data_valid),
    .ack(ack), .found_pattern(fnd[1]), .overrun(ovr[1]), .match_count(cnt[1]));

  pattern_detector_param #(.DATA_W(DW), .MAX_LEN(ML), .CNT_W(CW), .OVERLAP(1'b0)) u_no (
    .clk(clk), .reset_sync(reset_sync), .enable(enable), .cfg_load(cfg_load),
    .pattern(pattern), .pattern_len(pattern_len), .data(data), .data_valid(data_valid),
    .ack(ack), .found_pattern(fnd[0]), .overrun(ovr[0]), .match_count(cnt[0]));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit tail_match(input sym_q_t q);
    if (m_len == 0 || q.size() < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++)
      if (q[q.size() - m_len + j] != m_pat[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hq0.delete(); hq1.delete();
    m_len = 0;
    for (int i = 0; i < ML; i++) m_pat[i] = '0;
    for (int m = 0; m < 2; m++) begin
      m_fnd[m] = 0; m_ovr[m] = 0; m_cnt[m] = 0;
    end
  endtask

  // one clock edge of the reference using the inputs currently applied
  task automatic model_edge();
    bit mt [2];
    if (!enable) begin
      hq0.delete(); hq1.delete();
      mt[0] = 0; mt[1] = 0;
    end else begin
      if (data_valid) begin
        hq0.push_back(data); hq1.push_back(data);
        if (hq0.size() > ML) void'(hq0.pop_front());
        if (hq1.size() > ML) void'(hq1.pop_front());
      end
      mt[0] = data_valid && tail_match(hq0);
      mt[1] = data_valid && tail_match(hq1);
      if (mt[0]) hq0.delete();
    end
    for (int m = 0; m < 2; m++) begin
      if (mt[m] && m_fnd[m] && !ack) m_ovr[m] = 1;
      if (mt[m] && m_cnt[m] < (1 << CW) - 1) m_cnt[m]++;
      if (mt[m]) m_fnd[m] = 1;
      else if (ack) m_fnd[m] = 0;
    end
    if (!enable && cfg_load) begin
      m_len = (int'(pattern_len) > ML) ? ML : int'(pattern_len);
      for (int i = 0; i < ML; i++) m_pat[i] = pattern[i*DW +: DW];
      for (int m = 0; m < 2; m++) begin
        m_cnt[m] = 0; m_ovr[m] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s.found%0d", tag, m), int'(fnd[m]), int'(m_fnd[m]));
      chk($sformatf("%s.ovr%0d", tag, m),   int'(ovr[m]), int'(m_ovr[m]));
      chk($sformatf("%s.cnt%0d", tag, m),   int'(cnt[m]), m_cnt[m]);
    end
  endtask

  task automatic cyc(input string tag, input logic en, input logic cl,
                     input logic [DW-1:0] d, input logic v, input logic ak);
    enable = en; cfg_load = cl; data = d; data_valid = v; ack = ak;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic load(input string tag, input int len, input logic [ML*DW-1:0] pv);
    pattern = pv; pattern_len = LW'(len);
    cyc(tag, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic feed(input string tag, input logic [DW-1:0] d);
    cyc(tag, 1'b1, 1'b0, d, 1'b1, 1'b0);
  endtask

  task automatic idle(input string tag, input int n, input logic ak);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 8'h00, 1'b0, ak);
  endtask

  logic [ML*DW-1:0] p_bomb, p_aa;

  initial begin
    p_bomb = '0; p_bomb[31:0] = 32'h626D6F62;
    p_aa   = '0; p_aa[15:0]   = 16'h6161;
    reset_sync = 1'b0; enable = 1'b0; cfg_load = 1'b0; pattern = '0;
    pattern_len = '0; data = '0; data_valid = 1'b0; ack = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset_sync = 1'b1;

    // cfg_len=0 after reset never matches
    feed("nolen", 8'h00); feed("nolen", 8'h00);

    // T1 basic match
    load("t1.load", 4, p_bomb);
    feed("t1", 8'h62); feed("t1", 8'h6F); feed("t1", 8'h6D); feed("t1", 8'h62);
    // T3 found held without ack, then released
    idle("t3.hold", 5, 1'b0);
    idle("t3.ack", 1, 1'b1);
    idle("t3.after", 1, 1'b0);

    // T2 overlap vs non-overlap
    cyc("t2.dis", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    load("t2.load", 2, p_aa);
    feed("t2", 8'h61); feed("t2", 8'h61); feed("t2", 8'h61);
    // T4 second match while pending -> overrun
    feed("t4", 8'h61); feed("t4", 8'h61);
    idle("t4.sticky", 3, 1'b1);
    // match and ack on the same edge
    cyc("same", 1'b1, 1'b0, 8'h61, 1'b1, 1'b1);
    idle("same.clr", 1, 1'b1);
    cyc("t4.dis", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    load("t4.clr", 2, p_aa);

    // T5 gaps and a broken run
    load("t5.load", 4, p_bomb);
    feed("t5", 8'h62); idle("t5.gap", 2, 1'b0);
    feed("t5", 8'h6F); idle("t5.gap", 1, 1'b0);
    feed("t5", 8'h6D); idle("t5.gap", 3, 1'b0);
    feed("t5", 8'h62);
    idle("t5.ack", 1, 1'b1);
    feed("t5b", 8'h62); feed("t5b", 8'h6F); feed("t5b", 8'h00);
    feed("t5b", 8'h6D); feed("t5b", 8'h62);

    // clamp: length 15 behaves as 8
    load("clamp", 15, {8{8'h61}});
    for (int i = 0; i < 9; i++) feed("clamp", 8'h61);
    idle("clamp.ack", 1, 1'b1);

    // T6 async reset mid-pattern
    load("t6.load", 4, p_bomb);
    feed("t6", 8'h62); feed("t6", 8'h6F);
    #2 reset_sync = 1'b0;
    model_reset();
    #1 check_all("t6.async");
    @(negedge clk) reset_sync = 1'b1;
    feed("t6", 8'h6D); feed("t6", 8'h62);

    // randomized traffic over a small alphabet so matches are frequent
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        logic [ML*DW-1:0] pv;
        int ln;
        for (int k = 0; k < ML; k++) pv[k*DW +: DW] = DW'($urandom_range(1, 0) + 8'h61);
        ln = ($urandom_range(9, 0) == 0) ? $urandom_range(15, 0) : $urandom_range(4, 1);
        cyc("rnd.dis", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        load("rnd.load", ln, pv);
      end
      cyc("rnd", ($urandom_range(29, 0) != 0), ($urandom_range(9, 0) == 0),
          DW'($urandom_range(1, 0) + 8'h61), ($urandom_range(9, 0) < 7),
          ($urandom_range(9, 0) < 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
